dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 217 +++++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//
// Purpose:
//   Two-port arbiter in front of a single-ported 32-bit data memory. Port 0 is
//   the CPU load/store port, port 1 is the debug/loader port. Each access walks
//   through IDLE -> ACCESS -> RESP, so a request sampled in cycle N drives the
//   memory in cycle N+1 and is acknowledged in cycle N+2 (one access every
//   three cycles). Misaligned or out-of-range addresses never touch the memory;
//   they complete with err=1 and rdata=0.
//
// Configuration:
//   DMEM_ARB_RR_EN  defined   -> round-robin arbitration on collisions, using a
//                                one-bit "last granted" pointer (reset to 1).
//                   undefined -> fixed priority, port 0 always wins.
//
// Parameters:
//   WORDS      number of 32-bit words in the memory (legal word index 0..WORDS-1)
//
// Ports:
//   clk                 single clock, rising edge
//   reset               asynchronous, active-high reset
//   req0/req1           access requests (held until acknowledged)
//   we0/we1             1 = write, 0 = read
//   addr0/addr1         byte addresses
//   wdata0/wdata1       write data
//   ack0/ack1           one-cycle completion pulse
//   rdata0/rdata1       registered read data, stable until the next ack
//   err0/err1           error flag, valid with ack and stable until next ack
//   busy                high whenever the arbiter is not IDLE
//   MemWrite/MemRead    memory strobes, only ever high during ACCESS
//   Address/WriteData   memory address / write data, zero outside ACCESS
//   ReadData            combinational memory read data
// -----------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int WORDS = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic [31:0] addr0,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    output logic        ack0,
    output logic        ack1,
    output logic [31:0] rdata0,
    output logic [31:0] rdata1,
    output logic        err0,
    output logic        err1,
    output logic        busy,
    output logic        MemWrite,
    output logic        MemRead,
    output logic [31:0] Address,
    output logic [31:0] WriteData,
    input  logic [31:0] ReadData
);

    localparam logic [31:0] WORDS_U32 = 32'(WORDS);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_nextState;

    // Transaction latched at the IDLE edge; r_port = 1 means port 1 owns it.
    logic        r_we;
    logic        r_port;
    logic        r_err;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;

    logic [31:0] r_rdata0;
    logic [31:0] r_rdata1;
    logic        r_err0;
    logic        r_err1;

    logic        w_anyReq;
    logic        w_grant1;
    logic        w_selWe;
    logic        w_selErr;
    logic [31:0] w_selAddr;
    logic [31:0] w_selWdata;

    assign w_anyReq = req0 || req1;

`ifdef DMEM_ARB_RR_EN
    logic r_last;

    // On a collision the port that was not granted last time wins; a lone
    // request always wins.
    assign w_grant1 = req1 && (!req0 || !r_last);
`else
    // Fixed priority: port 1 only wins when port 0 is not asking.
    assign w_grant1 = req1 && !req0;
`endif

    assign w_selWe    = w_grant1 ? we1    : we0;
    assign w_selAddr  = w_grant1 ? addr1  : addr0;
    assign w_selWdata = w_grant1 ? wdata1 : wdata0;

    // The error decision is made once, at grant time, so ACCESS only has to
    // look at a single latched bit to suppress the memory strobes.
    assign w_selErr = (w_selAddr[1:0] != 2'b00) ||
                      ({2'b00, w_selAddr[31:2]} >= WORDS_U32);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic: every accepted request takes exactly three cycles.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (w_anyReq) w_nextState = ACCESS;
            ACCESS:  w_nextState = RESP;
            RESP:    w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // Requests are only looked at in IDLE; the winner's transaction is frozen
    // here so the requester may change its inputs freely afterwards.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_we    <= 1'b0;
            r_port  <= 1'b0;
            r_err   <= 1'b0;
            r_addr  <= 32'h0;
            r_wdata <= 32'h0;
`ifdef DMEM_ARB_RR_EN
            r_last  <= 1'b1;
`endif
        end else if (r_state == IDLE && w_anyReq) begin
            r_we    <= w_selWe;
            r_port  <= w_grant1;
            r_err   <= w_selErr;
            r_addr  <= w_selAddr;
            r_wdata <= w_selWdata;
`ifdef DMEM_ARB_RR_EN
            r_last  <= w_grant1;
`endif
        end
    end

    // Response registers are written at the edge that ends ACCESS so they are
    // already valid in the RESP cycle, alongside ack.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rdata0 <= 32'h0;
            r_rdata1 <= 32'h0;
            r_err0   <= 1'b0;
            r_err1   <= 1'b0;
        end else if (r_state == ACCESS) begin
            if (!r_port) begin
                r_err0 <= r_err;
                if (r_err) begin
                    r_rdata0 <= 32'h0;
                end else if (!r_we) begin
                    r_rdata0 <= ReadData;
                end
            end else begin
                r_err1 <= r_err;
                if (r_err) begin
                    r_rdata1 <= 32'h0;
                end else if (!r_we) begin
                    r_rdata1 <= ReadData;
                end
            end
        end
    end

    // Outputs decoded from the state so that reset clears them immediately.
    // Memory strobes stay low for a faulting access even though the address
    // is still presented.
    always_comb begin
        ack0      = 1'b0;
        ack1      = 1'b0;
        MemWrite  = 1'b0;
        MemRead   = 1'b0;
        Address   = 32'h0;
        WriteData = 32'h0;
        busy      = (r_state != IDLE);
        case (r_state)
            ACCESS: begin
                Address   = r_addr;
                WriteData = r_wdata;
                MemWrite  = r_we && !r_err;
                MemRead   = !r_we && !r_err;
            end
            RESP: begin
                ack0 = !r_port;
                ack1 = r_port;
            end
            default: begin
            end
        endcase
    end

    assign rdata0 = r_rdata0;
    assign rdata1 = r_rdata1;
    assign err0   = r_err0;
    assign err1   = r_err1;

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
//
// Testbench for dmem_arbiter. Provides a simple word memory behind the arbiter,
// a transaction-level reference model of the arbiter, a per-cycle compare
// process, directed scenarios with hand-computed expectations and a randomized
// phase. Define DMEM_ARB_RR_EN for both files to test the round-robin build.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

    localparam int WORDS = 1024;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0, req1, we0, we1;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic        ack0, ack1, err0, err1, busy, MemWrite, MemRead;
    logic [31:0] rdata0, rdata1, Address, WriteData, ReadData;

    logic [31:0] mem    [0:WORDS-1];
    logic [31:0] refMem [0:WORDS-1];

    int checks = 0;
    int errors = 0;
    bit cmpEn  = 1'b0;

    int          wrCnt = 0;
    int          accCnt = 0;
    logic [31:0] lastWrAddr = 32'h0;

    dmem_arbiter #(.WORDS(WORDS)) dut (
        .clk       (clk),
        .reset     (reset),
        .req0      (req0),
        .req1      (req1),
        .we0       (we0),
        .we1       (we1),
        .addr0     (addr0),
        .addr1     (addr1),
        .wdata0    (wdata0),
        .wdata1    (wdata1),
        .ack0      (ack0),
        .ack1      (ack1),
        .rdata0    (rdata0),
        .rdata1    (rdata1),
        .err0      (err0),
        .err1      (err1),
        .busy      (busy),
        .MemWrite  (MemWrite),
        .MemRead   (MemRead),
        .Address   (Address),
        .WriteData (WriteData),
        .ReadData  (ReadData)
    );

    always #5 clk = ~clk;

    // Memory behind the arbiter: combinational read, write on the clock edge.
    assign ReadData = mem[Address[11:2]];

    always @(posedge clk) begin
        if (MemWrite) mem[Address[11:2]] <= WriteData;
    end

    // Strobe statistics used by the directed scenarios.
    always @(negedge clk) begin
        if (MemWrite) begin
            wrCnt++;
            lastWrAddr = Address;
        end
        if (MemWrite || MemRead) accCnt++;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t",
                     name, actual, expected, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // mLeft counts the cycles the current transaction still occupies after the
    // grant: 2 = memory cycle, 1 = acknowledge cycle, 0 = free.
    int          mLeft;
    int          mPort;
    int          mLast;
    logic        mWe;
    logic        mErr;
    logic [31:0] mAddr;
    logic [31:0] mWdata;
    logic [31:0] mRdata [2];
    logic        mErrOut [2];
    logic [9:0]  mIdx;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mLeft = 0; mPort = 0; mLast = 1;
            mWe = 1'b0; mErr = 1'b0; mAddr = 32'h0; mWdata = 32'h0;
            mRdata[0] = 32'h0; mRdata[1] = 32'h0;
            mErrOut[0] = 1'b0; mErrOut[1] = 1'b0;
        end else if (mLeft == 0) begin
            if (req0 || req1) begin
                if (req0 && req1) begin
`ifdef DMEM_ARB_RR_EN
                    mPort = 1 - mLast;
`else
                    mPort = 0;
`endif
                end else begin
                    mPort = req1 ? 1 : 0;
                end
                mWe    = (mPort == 1) ? we1 : we0;
                mAddr  = (mPort == 1) ? addr1 : addr0;
                mWdata = (mPort == 1) ? wdata1 : wdata0;
                mErr   = ((mAddr % 4) != 0) || ((mAddr / 4) >= 32'(WORDS));
                mLast  = mPort;
                mLeft  = 2;
            end
        end else if (mLeft == 2) begin
            mIdx = mAddr[11:2];
            if (mErr) mRdata[mPort] = 32'h0;
            else if (mWe) refMem[mIdx] = mWdata;
            else mRdata[mPort] = refMem[mIdx];
            mErrOut[mPort] = mErr;
            mLeft = 1;
        end else begin
            mLeft = 0;
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (cmpEn) begin
            checkOutput("busy",      32'(busy),     32'(mLeft != 0));
            checkOutput("ack0",      32'(ack0),     32'(mLeft == 1 && mPort == 0));
            checkOutput("ack1",      32'(ack1),     32'(mLeft == 1 && mPort == 1));
            checkOutput("MemWrite",  32'(MemWrite), 32'(mLeft == 2 && mWe && !mErr));
            checkOutput("MemRead",   32'(MemRead),  32'(mLeft == 2 && !mWe && !mErr));
            checkOutput("Address",   Address,   (mLeft == 2) ? mAddr  : 32'h0);
            checkOutput("WriteData", WriteData, (mLeft == 2) ? mWdata : 32'h0);
            checkOutput("rdata0",    rdata0,    mRdata[0]);
            checkOutput("rdata1",    rdata1,    mRdata[1]);
            checkOutput("err0",      32'(err0),     32'(mErrOut[0]));
            checkOutput("err1",      32'(err1),     32'(mErrOut[1]));
        end
    end

    // Single transaction on one port; returns the ack latency in cycles
    // counted from the cycle the request is first presented.
    task automatic applyStimulus(input int port, input logic we,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 output int lat);
        bit seen = 1'b0;
        @(posedge clk); #1;
        if (port == 0) begin
            req0 = 1'b1; we0 = we; addr0 = addr; wdata0 = wdata;
        end else begin
            req1 = 1'b1; we1 = we; addr1 = addr; wdata1 = wdata;
        end
        lat = -1;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge clk);
            if ((port == 0 && ack0) || (port == 1 && ack1)) begin
                seen = 1'b1;
                lat  = k;
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("[TB] FAIL ack_timeout: got no ack on port %0d, expected ack within 10 cycles", port);
        end
        @(posedge clk); #1;
        if (port == 0) req0 = 1'b0; else req1 = 1'b0;
    endtask

    function automatic logic [31:0] randAddr();
        int sel = int'($urandom_range(0, 9));
        if (sel <= 6) return 32'($urandom_range(0, 15)) * 32'd4;
        if (sel == 7) return 32'($urandom_range(0, 255)) * 32'd4 + 32'($urandom_range(1, 3));
        if (sel == 8) return 32'(WORDS * 4) + 32'($urandom_range(0, 1000)) * 32'd4;
        return 32'($urandom_range(0, WORDS - 1)) * 32'd4;
    endfunction

    int lat;
    int n;
    int port;
    int cnt;
    int expPort [4];
    bit a0, a1;

    initial begin
        reset = 1'b1;
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        addr0 = 32'h0; addr1 = 32'h0; wdata0 = 32'h0; wdata1 = 32'h0;
        for (int i = 0; i < WORDS; i++) begin
            mem[i]    = 32'hC0DE0000 + 32'(i);
            refMem[i] = 32'hC0DE0000 + 32'(i);
        end

        // Reset values.
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_busy",      32'(busy),     32'h0);
        checkOutput("rst_ack0",      32'(ack0),     32'h0);
        checkOutput("rst_ack1",      32'(ack1),     32'h0);
        checkOutput("rst_err0",      32'(err0),     32'h0);
        checkOutput("rst_err1",      32'(err1),     32'h0);
        checkOutput("rst_rdata0",    rdata0,        32'h0);
        checkOutput("rst_rdata1",    rdata1,        32'h0);
        checkOutput("rst_MemWrite",  32'(MemWrite), 32'h0);
        checkOutput("rst_MemRead",   32'(MemRead),  32'h0);
        checkOutput("rst_Address",   Address,       32'h0);
        checkOutput("rst_WriteData", WriteData,     32'h0);
        #2 reset = 1'b0;
        cmpEn = 1'b1;

        // Port 0 write then read back.
        $display("[TB] port 0 write/read");
        wrCnt = 0;
        applyStimulus(0, 1'b1, 32'h10, 32'hDEADBEEF, lat);
        checkOutput("wr_latency",  32'(lat),   32'd2);
        checkOutput("wr_strobes",  32'(wrCnt), 32'd1);
        checkOutput("wr_address",  lastWrAddr, 32'h10);
        checkOutput("wr_mem4",     mem[4],     32'hDEADBEEF);
        applyStimulus(0, 1'b0, 32'h10, 32'h0, lat);
        checkOutput("rd_latency",  32'(lat),   32'd2);
        checkOutput("rd_rdata0",   rdata0,     32'hDEADBEEF);
        checkOutput("rd_err0",     32'(err0),  32'h0);

        // Error accesses.
        $display("[TB] error accesses");
        applyStimulus(1, 1'b0, 32'hC, 32'h0, lat);
        checkOutput("pre_rdata1",  rdata1,     32'hC0DE0003);
        accCnt = 0;
        applyStimulus(1, 1'b0, 32'h1000, 32'h0, lat);
        checkOutput("oor_latency", 32'(lat),   32'd2);
        checkOutput("oor_err1",    32'(err1),  32'h1);
        checkOutput("oor_rdata1",  rdata1,     32'h0);
        applyStimulus(0, 1'b1, 32'h6, 32'hFFFF0000, lat);
        checkOutput("mis_err0",    32'(err0),  32'h1);
        checkOutput("mis_rdata0",  rdata0,     32'h0);
        checkOutput("err_strobes", 32'(accCnt), 32'h0);
        checkOutput("mis_mem1",    mem[1],     32'hC0DE0001);

        // Reset in the middle of a write's ACCESS cycle.
        $display("[TB] reset during access");
        @(posedge clk); #1;
        req0 = 1'b1; we0 = 1'b1; addr0 = 32'h20; wdata0 = 32'h12345678;
        @(posedge clk); #1;
        req0 = 1'b0;
        checkOutput("acc_MemWrite", 32'(MemWrite), 32'h1);
        checkOutput("acc_Address",  Address,       32'h20);
        #2 reset = 1'b1;
        #1;
        checkOutput("arst_busy",      32'(busy),     32'h0);
        checkOutput("arst_ack0",      32'(ack0),     32'h0);
        checkOutput("arst_MemWrite",  32'(MemWrite), 32'h0);
        checkOutput("arst_MemRead",   32'(MemRead),  32'h0);
        checkOutput("arst_Address",   Address,       32'h0);
        checkOutput("arst_WriteData", WriteData,     32'h0);
        checkOutput("arst_err0",      32'(err0),     32'h0);
        checkOutput("arst_rdata0",    rdata0,        32'h0);
        @(posedge clk); #3;
        reset = 1'b0;
        cnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (ack0) cnt++;
        end
        checkOutput("arst_no_ack0", 32'(cnt), 32'h0);
        checkOutput("arst_mem8",    mem[8],   32'hC0DE0008);

        // Both ports hold reads from the same cycle (pointer is fresh from reset).
        $display("[TB] collisions");
`ifdef DMEM_ARB_RR_EN
        expPort = '{0, 1, 0, 1};
`else
        expPort = '{0, 0, 0, 0};
`endif
        @(posedge clk); #1;
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'h40;
        req1 = 1'b1; we1 = 1'b0; addr1 = 32'h44;
        n = 0;
        for (int k = 0; k < 30 && n < 4; k++) begin
            @(negedge clk);
            if (ack0 || ack1) begin
                port = ack1 ? 1 : 0;
                checkOutput("coll_cycle", 32'(k),    32'(2 + 3 * n));
                checkOutput("coll_port",  32'(port), 32'(expPort[n]));
                if (port == 0) checkOutput("coll_rdata0", rdata0, 32'hC0DE0010);
                else           checkOutput("coll_rdata1", rdata1, 32'hC0DE0011);
                n++;
            end
        end
        if (n < 4) checkOutput("coll_count", 32'(n), 32'd4);
        @(posedge clk); #1;
        req0 = 1'b0; req1 = 1'b0;
        repeat (2) @(posedge clk);

        // Port 1 holds its request across four back-to-back reads.
        $display("[TB] back-to-back reads");
        @(posedge clk); #1;
        req1 = 1'b1; we1 = 1'b0; addr1 = 32'h0;
        n = 0;
        for (int k = 0; k < 30 && n < 4; k++) begin
            @(negedge clk);
            if (ack1) begin
                checkOutput("b2b_cycle", 32'(k), 32'(2 + 3 * n));
                checkOutput("b2b_rdata", rdata1, 32'hC0DE0000 + 32'(n));
                n++;
                if (n < 4) begin
                    @(posedge clk); #1;
                    addr1 = 32'(4 * n);
                end
            end
        end
        if (n < 4) checkOutput("b2b_count", 32'(n), 32'd4);
        @(posedge clk); #1;
        req1 = 1'b0;
        repeat (2) @(posedge clk);

        // Randomized traffic; a request is only changed or dropped after its ack.
        $display("[TB] random traffic");
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            a0 = ack0;
            a1 = ack1;
            @(posedge clk); #1;
            if (!req0 || a0) begin
                if ($urandom_range(0, 2) != 0) begin
                    req0 = 1'b1; we0 = 1'($urandom_range(0, 1));
                    addr0 = randAddr(); wdata0 = $urandom();
                end else begin
                    req0 = 1'b0;
                end
            end
            if (!req1 || a1) begin
                if ($urandom_range(0, 2) != 0) begin
                    req1 = 1'b1; we1 = 1'($urandom_range(0, 1));
                    addr1 = randAddr(); wdata1 = $urandom();
                end else begin
                    req1 = 1'b0;
                end
            end
        end
        @(negedge clk);
        @(posedge clk); #1;
        req0 = 1'b0; req1 = 1'b0;
        repeat (8) @(posedge clk);
        checkOutput("end_idle", 32'(busy), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        errors++;
        $display("[TB] FAIL watchdog: got no completion, expected finish before 500000");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
